sram_writing_fsm: RTL and testbench

- Write-side counterpart to the SRAM playback reader. Loads a block of 16-bit audio samples into the external async SRAM before playback starts.
- Accepts samples on a valid/ready stream, for example from a loader or test pattern source.
- Writes them to consecutive addresses from BASE_ADDR, generating CE/OE/WE/UB/LB timing.
- Drives write data and an output-enable; the toplevel owns the SRAM_DQ tristate.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_pulse_counter.sv | 27 ++
 rtl/sram_writing_fsm.sv | 251 +++++++++++++++++++++++++
 tb/tb_sram_writing_fsm.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM widths and write-FSM state encoding
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SETUP,
        WRITE,
        HOLD,
        VERIFY,
        FINISH
    } sram_wr_state_t;

    // Width needed for a down-counter loaded with values up to max_val.
    function automatic int sram_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sram_pulse_counter.sv
// rtl/sram_pulse_counter.sv - loadable down-counter timing the WE and verify windows
module sram_pulse_counter #(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_writing_fsm.sv
// rtl/sram_writing_fsm.sv - streams samples into async SRAM; optional read-back check under SRAM_WRITE_VERIFY_EN
module sram_writing_fsm
    import sram_pkg::*;
#(
    parameter int                ADDR_W    = SRAM_ADDR_W,
    parameter int                DATA_W    = SRAM_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_WORDS = 1024,
    parameter int                WE_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_OUT,
    output logic              SRAM_DQ_OE,
    input  logic [DATA_W-1:0] SRAM_DQ_IN,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
    output logic              verify_err
);

    localparam int                CNT_W     = sram_cnt_width(WE_CYCLES);
    localparam logic [CNT_W-1:0]  WE_LOAD   = CNT_W'(WE_CYCLES - 1);
    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W+1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef SRAM_WRITE_VERIFY_EN
    localparam logic [CNT_W-1:0]  VFY_LOAD  = {{(CNT_W-1){1'b0}}, 1'b1};
`endif

    sram_wr_state_t r_state;
    sram_wr_state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_word_count;
    logic [DATA_W-1:0] r_data;
    logic              r_ce_n, r_oe_n, r_we_n, r_bl_n, r_dq_oe;
    logic              r_ready, r_busy, r_done;

    logic w_ce_n, w_oe_n, w_we_n, w_bl_n, w_dq_oe;
    logic w_ready, w_busy, w_done;
    logic w_handshake, w_advance, w_last_word, w_verify_cmp;
    logic w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val;

    sram_pulse_counter #(
        .CNT_W (CNT_W)
    ) u_pulse_counter (
        .i_clk      (Clk),
        .i_rst      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign w_handshake = r_ready && sample_valid;
    assign w_last_word = (({1'b0, r_word_count} + {{ADDR_W{1'b0}}, 1'b1}) == LAST_WORD);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_advance    = 1'b0;
        w_verify_cmp = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_val    = WE_LOAD;
        w_cnt_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (w_handshake) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_cnt_load = 1'b1;
                w_next     = WRITE;
            end
            WRITE: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_next = HOLD;
                end
            end
`ifdef SRAM_WRITE_VERIFY_EN
            HOLD: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = VFY_LOAD;
                w_next     = VERIFY;
            end
            VERIFY: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_verify_cmp = 1'b1;
                    w_advance    = 1'b1;
                    w_next       = w_last_word ? FINISH : WAIT_DATA;
                end
            end
`else
            HOLD: begin
                w_advance = 1'b1;
                w_next    = w_last_word ? FINISH : WAIT_DATA;
            end
`endif
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Decode from the next state so every SRAM control comes straight off a flop.
    always_comb begin
        w_ce_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_bl_n  = 1'b1;
        w_dq_oe = 1'b0;
        w_ready = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (w_next)
            IDLE: begin
                w_busy = 1'b0;
            end
            WAIT_DATA: begin
                w_ce_n  = 1'b0;
                w_ready = 1'b1;
            end
            SETUP, HOLD: begin
                w_ce_n  = 1'b0;
                w_bl_n  = 1'b0;
                w_dq_oe = 1'b1;
            end
            WRITE: begin
                w_ce_n  = 1'b0;
                w_bl_n  = 1'b0;
                w_dq_oe = 1'b1;
                w_we_n  = 1'b0;
            end
            VERIFY: begin
                w_ce_n = 1'b0;
                w_bl_n = 1'b0;
                w_oe_n = 1'b0;
            end
            FINISH: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_bl_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
            r_we_n  <= w_we_n;
            r_bl_n  <= w_bl_n;
            r_dq_oe <= w_dq_oe;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_data       <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_addr       <= BASE_ADDR;
                r_word_count <= '0;
            end else if (w_advance) begin
                r_addr       <= r_addr + ONE_A;
                r_word_count <= r_word_count + ONE_A;
            end
            if (w_handshake) begin
                r_data <= sample_data;
            end
        end
    end

`ifdef SRAM_WRITE_VERIFY_EN
    logic r_verify_err;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_verify_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_verify_err <= 1'b0;
        end else if (w_verify_cmp && (SRAM_DQ_IN != r_data)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
`else
    logic w_unused_dq_in;
    assign w_unused_dq_in = ^SRAM_DQ_IN;
    assign verify_err     = 1'b0;
`endif

    assign sample_ready = r_ready;
    assign SRAM_ADDR    = r_addr;
    assign SRAM_DQ_OUT  = r_data;
    assign SRAM_DQ_OE   = r_dq_oe;
    assign SRAM_CE_N    = r_ce_n;
    assign SRAM_OE_N    = r_oe_n;
    assign SRAM_WE_N    = r_we_n;
    assign SRAM_UB_N    = r_bl_n;
    assign SRAM_LB_N    = r_bl_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign word_count   = r_word_count;

endmodule

// File: tb/tb_sram_writing_fsm.sv
// tb/tb_sram_writing_fsm.sv - directed self-checking bench for sram_writing_fsm
`timescale 1ns/1ps
module tb_sram_writing_fsm;

`ifdef SRAM_WRITE_VERIFY_EN
    localparam int PER_WORD = 7;
    localparam bit VFY      = 1'b1;
`else
    localparam int PER_WORD = 5;
    localparam bit VFY      = 1'b0;
`endif
    localparam int LIM = 200;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_ready;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic        busy, done, verify_err;
    logic [19:0] word_count;

    logic        s1_start = 1'b0;
    logic        s1_valid = 1'b0;
    logic [15:0] s1_data = '0;
    logic        s1_ready;
    logic [19:0] s1_addr;
    logic [15:0] s1_dq_out;
    logic [15:0] s1_dq_in = 16'h5A5A;
    logic        s1_dq_oe, s1_ce_n, s1_oe_n, s1_we_n, s1_ub_n, s1_lb_n;
    logic        s1_busy, s1_done, s1_verr;
    logic [19:0] s1_wc;

    always #5 Clk = ~Clk;

    sram_writing_fsm #(
        .BASE_ADDR (20'h00010),
        .NUM_WORDS (4),
        .WE_CYCLES (2)
    ) u_dut (
        .Clk(Clk), .reset(reset), .start(start),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .busy(busy), .done(done), .word_count(word_count), .verify_err(verify_err)
    );

    sram_writing_fsm #(
        .BASE_ADDR (20'h00010),
        .NUM_WORDS (1),
        .WE_CYCLES (2)
    ) u_dut_one (
        .Clk(Clk), .reset(reset), .start(s1_start),
        .sample_valid(s1_valid), .sample_data(s1_data), .sample_ready(s1_ready),
        .SRAM_ADDR(s1_addr), .SRAM_DQ_OUT(s1_dq_out), .SRAM_DQ_OE(s1_dq_oe),
        .SRAM_DQ_IN(s1_dq_in), .SRAM_CE_N(s1_ce_n), .SRAM_OE_N(s1_oe_n),
        .SRAM_WE_N(s1_we_n), .SRAM_UB_N(s1_ub_n), .SRAM_LB_N(s1_lb_n),
        .busy(s1_busy), .done(s1_done), .word_count(s1_wc), .verify_err(s1_verr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // SRAM model plus a write-pulse recorder for u_dut
    logic [15:0] mem [0:63];
    logic        corrupt = 1'b0;
    int          cyc = 0, we_len = 0, we_start = 0;
    logic [19:0] we_addr;
    logic [15:0] we_data;
    logic [19:0] q_addr[$];
    logic [15:0] q_data[$];
    int          q_len[$];
    int          q_start[$];
    int          hold_err = 0, overlap_err = 0, done_cnt = 0;

    assign SRAM_DQ_IN = SRAM_OE_N ? 16'h0000 :
                        (mem[SRAM_ADDR[5:0]] ^ {15'b0, corrupt && (SRAM_ADDR == 20'h00012)});

    always @(negedge Clk) begin
        cyc++;
        if (reset) begin
            we_len = 0;
        end else begin
            if (!SRAM_WE_N) begin
                if (we_len == 0) begin
                    we_addr  = SRAM_ADDR;
                    we_data  = SRAM_DQ_OUT;
                    we_start = cyc;
                end else if (SRAM_ADDR !== we_addr || SRAM_DQ_OUT !== we_data) begin
                    hold_err++;
                end
                if (!SRAM_DQ_OE || SRAM_CE_N || SRAM_UB_N || SRAM_LB_N) hold_err++;
                mem[SRAM_ADDR[5:0]] = SRAM_DQ_OUT;
                we_len++;
            end else if (we_len > 0) begin
                q_addr.push_back(we_addr);
                q_data.push_back(we_data);
                q_len.push_back(we_len);
                q_start.push_back(we_start);
                we_len = 0;
            end
            if (done) done_cnt++;
        end
        if (!SRAM_OE_N && (SRAM_DQ_OE || !SRAM_WE_N)) overlap_err++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        q_len.delete();
        q_start.delete();
        done_cnt = 0;
        hold_err = 0;
    endtask

    task automatic send(input logic [15:0] d);
        int t = 0;
        sample_data  = d;
        sample_valid = 1'b1;
        while (!sample_ready && t < LIM) begin
            tick();
            t++;
        end
        check_eq("handshake_timeout", 32'(t >= LIM), 32'd0);
        tick();
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < LIM) begin
            tick();
            t++;
        end
        check_eq("done_timeout", 32'(t >= LIM), 32'd0);
    endtask

    task automatic wait_we_low();
        int t = 0;
        while (SRAM_WE_N && t < LIM) begin
            tick();
            t++;
        end
        check_eq("we_low_timeout", 32'(t >= LIM), 32'd0);
    endtask

    initial begin
        int bad, t, seen;
        logic [19:0] wa;
        logic [15:0] wd;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, t;
        bit seen;
        logic [19:0] wa;
        logic [15:0] wd;

        // Reset state
        tick();
        tick();
        check_eq("rst_ctrl_n", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        check_eq("rst_dq", 32'({SRAM_DQ_OE, SRAM_DQ_OUT}), 32'h0);
        check_eq("rst_addr", 32'(SRAM_ADDR), 32'h10);
        check_eq("rst_flags", 32'({sample_ready, busy, done, verify_err}), 32'h0);
        check_eq("rst_wc", 32'(word_count), 32'h0);
        reset = 1'b0;
        tick();
        check_eq("idle_busy", 32'(busy), 32'h0);

        // Block of four, continuous valid
        clear_mon();
        pulse_start();
        check_eq("wait_ready", 32'({busy, sample_ready, SRAM_CE_N}), 32'h6);
        for (int i = 0; i < 4; i++) send(16'hA001 + 16'(i));
        sample_valid = 1'b0;
        wait_done();
        tick();
        check_eq("t1_done_len", 32'({done, busy}), 32'h0);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t1_wc", 32'(word_count), 32'd4);
        check_eq("t1_nwrites", 32'(q_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            check_eq("t1_addr", 32'(q_addr[i]), 32'h10 + 32'(i));
            check_eq("t1_data", 32'(q_data[i]), 32'hA001 + 32'(i));
            check_eq("t1_we_len", 32'(q_len[i]), 32'd2);
            if (i > 0) check_eq("t1_spacing", 32'(q_start[i] - q_start[i-1]), 32'(PER_WORD));
        end
        check_eq("t1_hold", 32'(hold_err), 32'd0);

        // Valid withheld for 10 cycles before word 2
        clear_mon();
        pulse_start();
        send(16'hB001);
        sample_valid = 1'b0;
        t = 0;
        while (!sample_ready && t < LIM) begin
            tick();
            t++;
        end
        check_eq("t2_ready_timeout", 32'(t >= LIM), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!sample_ready || SRAM_CE_N || !SRAM_WE_N) bad++;
            tick();
        end
        check_eq("t2_stall_state", 32'(bad), 32'd0);
        check_eq("t2_stall_writes", 32'(q_addr.size()), 32'd1);
        send(16'hB002);
        send(16'hB003);
        send(16'hB004);
        sample_valid = 1'b0;
        wait_done();
        tick();
        check_eq("t2_nwrites", 32'(q_addr.size()), 32'd4);
        if (q_addr.size() > 1) begin
            check_eq("t2_w2_addr", 32'(q_addr[1]), 32'h11);
            check_eq("t2_w2_data", 32'(q_data[1]), 32'hB002);
        end

        // start during a write and in the done cycle is ignored
        clear_mon();
        pulse_start();
        send(16'hC001);
        wait_we_low();
        pulse_start();
        check_eq("t3_addr_mid", 32'(SRAM_ADDR), 32'h10);
        send(16'hC002);
        send(16'hC003);
        send(16'hC004);
        sample_valid = 1'b0;
        wait_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t3_start_in_done", 32'({busy, sample_ready}), 32'h0);
        check_eq("t3_wc", 32'(word_count), 32'd4);
        check_eq("t3_last_addr", 32'(q_addr.size() == 4 ? q_addr[3] : 20'hFFFFF), 32'h13);
        pulse_start();
        check_eq("t3_restart", 32'({busy, sample_ready}), 32'h3);
        check_eq("t3_restart_addr", 32'(SRAM_ADDR), 32'h10);
        check_eq("t3_restart_wc", 32'(word_count), 32'd0);

        // Async reset in the first WE-low cycle
        send(16'hD001);
        sample_valid = 1'b0;
        wait_we_low();
        reset = 1'b1;
        #1;
        check_eq("t4_we_n", 32'(SRAM_WE_N), 32'h1);
        check_eq("t4_dq_oe", 32'(SRAM_DQ_OE), 32'h0);
        check_eq("t4_busy", 32'(busy), 32'h0);
        check_eq("t4_addr", 32'(SRAM_ADDR), 32'h10);
        tick();
        reset = 1'b0;
        tick();

        // NUM_WORDS = 1: done four cycles after the cycle following the handshake
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        s1_data  = 16'h5A5A;
        s1_valid = 1'b1;
        t = 0;
        while (!s1_ready && t < LIM) begin
            tick();
            t++;
        end
        check_eq("t5_ready_timeout", 32'(t >= LIM), 32'd0);
        tick();
        s1_valid = 1'b0;
        t = 0;
        seen = 1'b0;
        wa = '0;
        wd = '0;
        while (!s1_done && t < 50) begin
            if (!s1_we_n && !seen) begin
                seen = 1'b1;
                wa = s1_addr;
                wd = s1_dq_out;
            end
            tick();
            t++;
        end
        check_eq("t5_done_latency", 32'(t), 32'(PER_WORD - 1));
        check_eq("t5_we_seen", 32'(seen), 32'h1);
        check_eq("t5_addr", 32'(wa), 32'h10);
        check_eq("t5_data", 32'(wd), 32'h5A5A);
        check_eq("t5_wc", 32'(s1_wc), 32'd1);
        tick();

        // Read-back corruption at 0x12
        clear_mon();
        corrupt = 1'b1;
        pulse_start();
        send(16'hE001);
        send(16'hE002);
        send(16'hE003);
        check_eq("t6_verr_before", 32'(verify_err), 32'h0);
        send(16'hE004);
        check_eq("t6_verr_after_w3", 32'(verify_err), 32'(VFY));
        sample_valid = 1'b0;
        wait_done();
        check_eq("t6_verr_at_done", 32'(verify_err), 32'(VFY));
        tick();
        corrupt = 1'b0;
        pulse_start();
        check_eq("t6_verr_cleared", 32'(verify_err), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        check_eq("oe_overlap", 32'(overlap_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
